// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
//   REQ_ALU / REQ_LOAD : requester indices (0 = ALU writeback, 1 = load unit)
//   REG_W / DATA_W     : register-address and data widths
//   wb_req_t           : one writeback request payload (destination + data)
package regfile_wb_arbiter_pkg;

   localparam int unsigned REG_W    = 5;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned NUM_REGS = 32;

   localparam logic [0:0] REQ_ALU  = 1'b0;
   localparam logic [0:0] REQ_LOAD = 1'b1;

   typedef logic [REG_W-1:0]  reg_addr_t;
   typedef logic [DATA_W-1:0] data_t;

   typedef struct packed {
      reg_addr_t addr;
      data_t     data;
   } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the pipeline and the writeback arbiter.
//   iwReq*/iwReg*/iwData*/owGnt* : two writeback requesters (0 = ALU, 1 = load)
//   iwIssue/iwIssueReg           : destination register of an issuing instruction
//   iwChkReg*/owBusy*            : source-operand pending-write lookup
//   owWriteEnable/Reg/Data       : register file write port (registered)
// The slave modport is the arbiter; the master modport is the pipeline side.
interface regfile_wb_arbiter_if;
   import regfile_wb_arbiter_pkg::*;

   logic      iwReq0;
   reg_addr_t iwReg0;
   data_t     iwData0;
   logic      owGnt0;

   logic      iwReq1;
   reg_addr_t iwReg1;
   data_t     iwData1;
   logic      owGnt1;

   logic      iwIssue;
   reg_addr_t iwIssueReg;

   reg_addr_t iwChkReg1;
   reg_addr_t iwChkReg2;
   logic      owBusy1;
   logic      owBusy2;

   logic      owWriteEnable;
   reg_addr_t owWriteReg;
   data_t     owWriteData;

   modport slave (
      input  iwReq0, iwReg0, iwData0,
      input  iwReq1, iwReg1, iwData1,
      input  iwIssue, iwIssueReg,
      input  iwChkReg1, iwChkReg2,
      output owGnt0, owGnt1,
      output owBusy1, owBusy2,
      output owWriteEnable, owWriteReg, owWriteData
   );

   modport master (
      output iwReq0, iwReg0, iwData0,
      output iwReq1, iwReg1, iwData1,
      output iwIssue, iwIssueReg,
      output iwChkReg1, iwChkReg2,
      input  owGnt0, owGnt1,
      input  owBusy1, owBusy2,
      input  owWriteEnable, owWriteReg, owWriteData
   );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter_2.sv
// Two-way request/grant arbiter with a last-granted pointer.
//   iwClk, iwRst : clock, synchronous active-high reset
//   iwReq[1:0]   : request vector
//   owGnt[1:0]   : one-hot (or zero) grant, combinational, forced to 0 in reset
// pRoundRobin=1 favours the requester not granted most recently on contention;
// pRoundRobin=0 always favours requester 0.
module rr_arbiter_2 #(
   parameter int unsigned pRoundRobin = 1
) (
   input  logic       iwClk,
   input  logic       iwRst,
   input  logic [1:0] iwReq,
   output logic [1:0] owGnt
);

   logic       r_last;
   logic [1:0] w_gnt;

   // Grant selection
   always_comb begin
      w_gnt = 2'b00;
      if (!iwRst) begin
         case (iwReq)
            2'b01:   w_gnt = 2'b01;
            2'b10:   w_gnt = 2'b10;
            2'b11: begin
               if ((pRoundRobin != 0) && (r_last == 1'b0)) w_gnt = 2'b10;
               else                                       w_gnt = 2'b01;
            end
            default: w_gnt = 2'b00;
         endcase
      end
   end

   // Pointer resets to 1 so requester 0 wins the first contention
   always_ff @(posedge iwClk) begin
      if (iwRst)       r_last <= 1'b1;
      else if (|w_gnt) r_last <= w_gnt[1];
   end

   assign owGnt = w_gnt;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter with pending-write scoreboard.
//   iwClk, iwRst : clock, synchronous active-high reset
//   bus (slave)  : two writeback requesters with same-cycle grants, issue-side
//                  scoreboard set, busy lookup for two source registers, and the
//                  registered register-file write port (latency 1 from grant).
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int unsigned pRoundRobin = 1
) (
   input  logic                 iwClk,
   input  logic                 iwRst,
   regfile_wb_arbiter_if.slave  bus
);

   logic [1:0]          w_req;
   logic [1:0]          w_gnt;
   logic                w_any_gnt;
   logic                w_wr_en;
   wb_req_t             w_sel;

   logic                r_we;
   reg_addr_t           r_reg;
   data_t               r_data;

   logic [NUM_REGS-1:0] r_pending;
   logic [NUM_REGS-1:0] w_set;
   logic [NUM_REGS-1:0] w_clr;
   logic [NUM_REGS-1:0] w_pending_nxt;

   assign w_req = {bus.iwReq1, bus.iwReq0};

   rr_arbiter_2 #(
      .pRoundRobin (pRoundRobin)
   ) u_arb (
      .iwClk (iwClk),
      .iwRst (iwRst),
      .iwReq (w_req),
      .owGnt (w_gnt)
   );

   assign bus.owGnt0 = w_gnt[REQ_ALU];
   assign bus.owGnt1 = w_gnt[REQ_LOAD];

   // Mux the granted payload
   always_comb begin
      w_sel = '{addr: bus.iwReg0, data: bus.iwData0};
      if (w_gnt[REQ_LOAD]) w_sel = '{addr: bus.iwReg1, data: bus.iwData1};
   end

   assign w_any_gnt = |w_gnt;
   // Writes to r0 are acknowledged but never reach the register file
   assign w_wr_en   = w_any_gnt && (w_sel.addr != '0);

   // Write-port register; address/data hold when nothing is granted
   always_ff @(posedge iwClk) begin
      if (iwRst) begin
         r_we   <= 1'b0;
         r_reg  <= '0;
         r_data <= '0;
      end else begin
         r_we <= w_wr_en;
         if (w_any_gnt) begin
            r_reg  <= w_sel.addr;
            r_data <= w_sel.data;
         end
      end
   end

   assign bus.owWriteEnable = r_we;
   assign bus.owWriteReg    = r_reg;
   assign bus.owWriteData   = r_data;

   // Scoreboard next state: set wins over clear; r0 never pending
   always_comb begin
      w_set = '0;
      w_clr = '0;
      if (bus.iwIssue) w_set[bus.iwIssueReg] = 1'b1;
      if (w_any_gnt)   w_clr[w_sel.addr]     = 1'b1;
      w_pending_nxt    = (r_pending & ~w_clr) | w_set;
      w_pending_nxt[0] = 1'b0;
   end

   always_ff @(posedge iwClk) begin
      if (iwRst) r_pending <= '0;
      else       r_pending <= w_pending_nxt;
   end

   // Busy comes from registered state only
   assign bus.owBusy1 = r_pending[bus.iwChkReg1];
   assign bus.owBusy2 = r_pending[bus.iwChkReg2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (round-robin instance plus
// a fixed-priority instance for the contention case).
module tb_regfile_wb_arbiter;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   regfile_wb_arbiter_if bus ();
   regfile_wb_arbiter_if bus_fp ();

   regfile_wb_arbiter #(.pRoundRobin(1)) u_dut (
      .iwClk (clk),
      .iwRst (rst),
      .bus   (bus)
   );

   regfile_wb_arbiter #(.pRoundRobin(0)) u_dut_fp (
      .iwClk (clk),
      .iwRst (rst),
      .bus   (bus_fp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic drive_idle();
      bus.iwReq0 = 1'b0;  bus.iwReg0 = 5'd0;  bus.iwData0 = 32'd0;
      bus.iwReq1 = 1'b0;  bus.iwReg1 = 5'd0;  bus.iwData1 = 32'd0;
      bus.iwIssue = 1'b0; bus.iwIssueReg = 5'd0;
      bus.iwChkReg1 = 5'd0; bus.iwChkReg2 = 5'd0;
      bus_fp.iwReq0 = 1'b0;  bus_fp.iwReg0 = 5'd0;  bus_fp.iwData0 = 32'd0;
      bus_fp.iwReq1 = 1'b0;  bus_fp.iwReg1 = 5'd0;  bus_fp.iwData1 = 32'd0;
      bus_fp.iwIssue = 1'b0; bus_fp.iwIssueReg = 5'd0;
      bus_fp.iwChkReg1 = 5'd0; bus_fp.iwChkReg2 = 5'd0;
   endtask

   task automatic after_pos();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1;
      drive_idle();

      // Reset: grants suppressed, outputs cleared
      bus.iwReq0 = 1'b1; bus.iwReg0 = 5'd5; bus.iwData0 = 32'h0000_0055;
      @(negedge clk); #1;
      check("rst_gnt0", 32'(bus.owGnt0), 32'd0);
      check("rst_gnt1", 32'(bus.owGnt1), 32'd0);
      after_pos();
      check("rst_we",    32'(bus.owWriteEnable), 32'd0);
      check("rst_wreg",  32'(bus.owWriteReg),    32'd0);
      check("rst_wdata", bus.owWriteData,        32'd0);
      check("rst_busy1", 32'(bus.owBusy1),       32'd0);

      // Single request, latency 1
      @(negedge clk);
      rst = 1'b0;
      bus.iwReq0 = 1'b1; bus.iwReg0 = 5'd5; bus.iwData0 = 32'hDEAD_BEEF;
      #1;
      check("single_gnt0", 32'(bus.owGnt0), 32'd1);
      check("single_gnt1", 32'(bus.owGnt1), 32'd0);
      after_pos();
      check("single_we",    32'(bus.owWriteEnable), 32'd1);
      check("single_wreg",  32'(bus.owWriteReg),    32'd5);
      check("single_wdata", bus.owWriteData,        32'hDEAD_BEEF);

      // No grant: enable drops, address/data hold
      @(negedge clk);
      bus.iwReq0 = 1'b0;
      #1;
      check("idle_gnt0", 32'(bus.owGnt0), 32'd0);
      after_pos();
      check("idle_we",    32'(bus.owWriteEnable), 32'd0);
      check("idle_wreg",  32'(bus.owWriteReg),    32'd5);
      check("idle_wdata", bus.owWriteData,        32'hDEAD_BEEF);

      // Contention after reset: RR alternates 0,1,0,1; fixed priority 0,0,0,0
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      bus.iwReq0 = 1'b1; bus.iwReg0 = 5'd1; bus.iwData0 = 32'h1111_1111;
      bus.iwReq1 = 1'b1; bus.iwReg1 = 5'd2; bus.iwData1 = 32'h2222_2222;
      bus_fp.iwReq0 = 1'b1; bus_fp.iwReg0 = 5'd1; bus_fp.iwData0 = 32'h1111_1111;
      bus_fp.iwReq1 = 1'b1; bus_fp.iwReg1 = 5'd2; bus_fp.iwData1 = 32'h2222_2222;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("rr_gnt0_%0d", i), 32'(bus.owGnt0), (i % 2 == 0) ? 32'd1 : 32'd0);
         check($sformatf("rr_gnt1_%0d", i), 32'(bus.owGnt1), (i % 2 == 0) ? 32'd0 : 32'd1);
         check($sformatf("fp_gnt0_%0d", i), 32'(bus_fp.owGnt0), 32'd1);
         check($sformatf("fp_gnt1_%0d", i), 32'(bus_fp.owGnt1), 32'd0);
         after_pos();
         check($sformatf("rr_wreg_%0d", i), 32'(bus.owWriteReg), (i % 2 == 0) ? 32'd1 : 32'd2);
         @(negedge clk);
      end
      drive_idle();

      // Write to r0: granted but not written
      bus.iwReq1 = 1'b1; bus.iwReg1 = 5'd0; bus.iwData1 = 32'h1234_5678;
      #1;
      check("r0_gnt1", 32'(bus.owGnt1), 32'd1);
      after_pos();
      check("r0_we", 32'(bus.owWriteEnable), 32'd0);

      // Scoreboard: issue r7, busy from next cycle, no bypass
      @(negedge clk);
      bus.iwReq1 = 1'b0;
      bus.iwIssue = 1'b1; bus.iwIssueReg = 5'd7;
      bus.iwChkReg1 = 5'd7; bus.iwChkReg2 = 5'd7;
      #1;
      check("sb_nobypass", 32'(bus.owBusy1), 32'd0);
      after_pos();
      check("sb_busy1_set", 32'(bus.owBusy1), 32'd1);
      check("sb_busy2_set", 32'(bus.owBusy2), 32'd1);

      // Grant r7: busy until the edge after the grant
      @(negedge clk);
      bus.iwIssue = 1'b0;
      bus.iwReq0 = 1'b1; bus.iwReg0 = 5'd7; bus.iwData0 = 32'hA5A5_A5A5;
      #1;
      check("sb_gnt0", 32'(bus.owGnt0), 32'd1);
      check("sb_busy_during_gnt", 32'(bus.owBusy1), 32'd1);
      after_pos();
      check("sb_busy_clr", 32'(bus.owBusy1), 32'd0);
      check("sb_we", 32'(bus.owWriteEnable), 32'd1);
      check("sb_wreg", 32'(bus.owWriteReg), 32'd7);

      // Reissue r7, then issue and grant r7 together: set wins
      @(negedge clk);
      bus.iwReq0 = 1'b0;
      bus.iwIssue = 1'b1; bus.iwIssueReg = 5'd7;
      after_pos();
      check("sb_reissue", 32'(bus.owBusy1), 32'd1);
      @(negedge clk);
      bus.iwReq1 = 1'b1; bus.iwReg1 = 5'd7; bus.iwData1 = 32'h0000_0077;
      #1;
      check("sb_same_gnt1", 32'(bus.owGnt1), 32'd1);
      after_pos();
      check("sb_set_wins", 32'(bus.owBusy1), 32'd1);

      // Mid-operation reset with pending r3/r4 and a live request
      @(negedge clk);
      bus.iwReq1 = 1'b0;
      bus.iwIssue = 1'b1; bus.iwIssueReg = 5'd3;
      bus.iwChkReg1 = 5'd3; bus.iwChkReg2 = 5'd4;
      @(negedge clk);
      bus.iwIssueReg = 5'd4;
      after_pos();
      check("mr_busy3", 32'(bus.owBusy1), 32'd1);
      check("mr_busy4", 32'(bus.owBusy2), 32'd1);
      @(negedge clk);
      bus.iwIssue = 1'b0;
      rst = 1'b1;
      bus.iwReq0 = 1'b1; bus.iwReg0 = 5'd9; bus.iwData0 = 32'h0000_CAFE;
      #1;
      check("mr_gnt0", 32'(bus.owGnt0), 32'd0);
      after_pos();
      check("mr_we",    32'(bus.owWriteEnable), 32'd0);
      check("mr_wreg",  32'(bus.owWriteReg),    32'd0);
      check("mr_wdata", bus.owWriteData,        32'd0);
      check("mr_busy1", 32'(bus.owBusy1),       32'd0);
      check("mr_busy2", 32'(bus.owBusy2),       32'd0);

      // Requester re-presents after reset
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("re_gnt0", 32'(bus.owGnt0), 32'd1);
      after_pos();
      check("re_we",    32'(bus.owWriteEnable), 32'd1);
      check("re_wreg",  32'(bus.owWriteReg),    32'd9);
      check("re_wdata", bus.owWriteData,        32'h0000_CAFE);

      // Same destination from both: serialised, later grant's data last
      @(negedge clk);
      bus.iwReq0 = 1'b1; bus.iwReg0 = 5'd10; bus.iwData0 = 32'hA0A0_A0A0;
      bus.iwReq1 = 1'b1; bus.iwReg1 = 5'd10; bus.iwData1 = 32'hB1B1_B1B1;
      #1;
      check("same_gnt1", 32'(bus.owGnt1), 32'd1);
      check("same_gnt0", 32'(bus.owGnt0), 32'd0);
      after_pos();
      check("same_wdata1", bus.owWriteData, 32'hB1B1_B1B1);
      @(negedge clk);
      bus.iwReq1 = 1'b0;
      #1;
      check("same_gnt0_2", 32'(bus.owGnt0), 32'd1);
      after_pos();
      check("same_wreg2",  32'(bus.owWriteReg), 32'd10);
      check("same_wdata2", bus.owWriteData,     32'hA0A0_A0A0);

      @(negedge clk);
      drive_idle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
